// File: rtl/conv_stream_window.sv
// Streaming 2-D convolution: line buffers feed a square window, each tap is
// multiplied by a loadable coefficient, and the products are summed into one result.

module conv_tap #(
  parameter int bitwidth = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic [bitwidth-1:0]     a,
  input  logic [bitwidth-1:0]     b,
  output logic [2*bitwidth-1:0]   p
);
  logic [2*bitwidth-1:0] p_q, p_d;

  always_comb p_d = en ? (2*bitwidth)'(a) * (2*bitwidth)'(b) : p_q;

  always_ff @(posedge clock) begin
    if (reset) p_q <= '0;
    else       p_q <= p_d;
  end

  assign p = p_q;
endmodule

module conv_stream_window #(
  parameter int bitwidth    = 8,
  parameter int filterWidth = 3,
  parameter int imageWidth  = 28,
  parameter int imageHeight = 28,
  parameter int accWidth    = 20
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [bitwidth-1:0]                           data_in,
  input  logic                                          coef_wr_en,
  input  logic [$clog2(filterWidth*filterWidth)-1:0]    coef_addr,
  input  logic [bitwidth-1:0]                           coef_data,
  output logic [accWidth-1:0]                           result,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic                                          frame_done
);
  localparam int FS = filterWidth * filterWidth;
  localparam int AW = $clog2(FS);
  localparam int CW = $clog2(imageWidth);
  localparam int RW = $clog2(imageHeight);
  localparam int PW = 2 * bitwidth;

  logic adv, acc, win_ok, last_px;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  // [0] window valid, [1] product stage, [2] result stage
  logic [2:0] vld_pipe_q, vld_pipe_d, last_pipe_q, last_pipe_d;
  logic [FS-1:0][bitwidth-1:0] win_q, win_d, coef_q, coef_d;
  logic [FS-1:0][PW-1:0] prod;
  logic [accWidth-1:0] result_q, result_d, sum;
  logic [filterWidth-2:0][bitwidth-1:0] lb_rd;
  logic [filterWidth-1:0][bitwidth-1:0] col_in;
  logic [bitwidth-1:0] lb_mem [filterWidth-1][imageWidth];

  assign adv      = !vld_pipe_q[2] || out_ready;
  assign acc      = in_valid && adv;
  assign in_ready = adv;
  assign win_ok   = (row_q >= RW'(filterWidth-1)) && (col_q >= CW'(filterWidth-1));
  assign last_px  = (row_q == RW'(imageHeight-1)) && (col_q == CW'(imageWidth-1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (acc) begin
      if (col_q == CW'(imageWidth-1)) begin
        col_d = '0;
        row_d = (row_q == RW'(imageHeight-1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // A bubble (advance without accept) shifts a zero into the valid pipe.
  always_comb begin
    vld_pipe_d  = vld_pipe_q;
    last_pipe_d = last_pipe_q;
    if (adv) begin
      vld_pipe_d  = {vld_pipe_q[1:0], acc && win_ok};
      last_pipe_d = {last_pipe_q[1:0], acc && win_ok && last_px};
    end
  end

  // Buffer k returns the pixel k+1 rows above; the oldest row lands on top.
  assign col_in[filterWidth-1] = data_in;
  for (genvar k = 0; k < filterWidth-1; k++) begin : g_lb
    assign lb_rd[k]                 = lb_mem[k][col_q];
    assign col_in[filterWidth-2-k]  = lb_rd[k];
    if (k == 0) begin : g_first
      always_ff @(posedge clock) if (acc) lb_mem[k][col_q] <= data_in;
    end else begin : g_chain
      always_ff @(posedge clock) if (acc) lb_mem[k][col_q] <= lb_rd[k-1];
    end
  end

  always_comb begin
    win_d = win_q;
    if (acc) begin
      for (int r = 0; r < filterWidth; r++) begin
        for (int j = 0; j < filterWidth-1; j++) win_d[r*filterWidth+j] = win_q[r*filterWidth+j+1];
        win_d[r*filterWidth+filterWidth-1] = col_in[r];
      end
    end
  end

  always_comb begin
    coef_d = coef_q;
    for (int i = 0; i < FS; i++)
      if (coef_wr_en && coef_addr == AW'(i)) coef_d[i] = coef_data;
  end

  for (genvar i = 0; i < FS; i++) begin : g_tap
    conv_tap #(.bitwidth(bitwidth)) u_tap (
      .clock(clock), .reset(reset), .en(adv),
      .a(win_q[i]), .b(coef_q[i]), .p(prod[i])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < FS; i++) sum = sum + accWidth'(prod[i]);
    result_d = adv ? sum : result_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      win_q       <= '0;
      result_q    <= '0;
      for (int i = 0; i < FS; i++) coef_q[i] <= bitwidth'(FS - i);
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      win_q       <= win_d;
      result_q    <= result_d;
      coef_q      <= coef_d;
    end
  end

  assign result     = result_q;
  assign out_valid  = vld_pipe_q[2];
  assign frame_done = last_pipe_q[2];
endmodule

// File: tb/tb_conv_stream_window.sv
// Bench for conv_stream_window on a 5x5 frame: table-driven frames plus
// backpressure and mid-frame reset sequences, checked through a result scoreboard.

module tb_conv_stream_window;
  logic        clock = 1'b0;
  logic        reset, in_valid, in_ready, coef_wr_en, out_valid, out_ready, frame_done;
  logic [7:0]  data_in, coef_data;
  logic [3:0]  coef_addr;
  logic [19:0] result;

  conv_stream_window #(.bitwidth(8), .filterWidth(3), .imageWidth(5), .imageHeight(5), .accWidth(20)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_data(coef_data),
    .result(result), .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  typedef struct { int res; bit fd; } exp_t;
  typedef struct { bit ramp; bit toggle; int coef_all; int seq; } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[4];
  int   seqs[3][9] = '{'{174, 219, 264, 399, 444, 489, 624, 669, 714},
                       '{54, 63, 72, 99, 108, 117, 144, 153, 162},
                       '{585225, 585225, 585225, 585225, 585225, 585225, 585225, 585225, 585225}};
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, acc12_cyc = 0;
  bit   lat_arm = 0, mon_en = 1;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic send_px(input logic [7:0] px, input bit push, input int expv, input bit fd, input bit lat);
    int n = 0;
    data_in  = px;
    in_valid = 1'b1;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    if (push) sb.push_back('{expv, fd});
    if (lat) begin acc12_cyc = cyc + 1; lat_arm = 1; end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input bit ramp, input bit toggle, input int seq, input bit push_en,
                           input int npx, input bit lat_en);
    int k = 0;
    for (int p = 0; p < npx; p++) begin
      bit win;
      logic [7:0] px;
      win = (p / 5 >= 2) && (p % 5 >= 2);
      px  = ramp ? 8'(p) : 8'hFF;
      send_px(px, push_en && win, win ? seqs[seq][k] : 0, p == 24, lat_en && p == 12);
      if (win) k++;
      if (toggle) begin @(posedge clock); #1; end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() > 0; i++) begin @(posedge clock); #1; end
    repeat (4) begin @(posedge clock); #1; end
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic write_all(input logic [7:0] v);
    coef_wr_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      coef_addr = 4'(i); coef_data = v;
      @(posedge clock); #1;
    end
    coef_data = 8'd0;
    coef_addr = 4'd9;  @(posedge clock); #1;
    coef_addr = 4'd15; @(posedge clock); #1;
    coef_wr_en = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 0,   0};
    tbl[1] = '{1'b1, 1'b1, 0,   0};
    tbl[2] = '{1'b1, 1'b0, 1,   1};
    tbl[3] = '{1'b0, 1'b0, 255, 2};

    reset = 1'b1; in_valid = 1'b0; data_in = '0; out_ready = 1'b1;
    coef_wr_en = 1'b0; coef_addr = '0; coef_data = '0;

    fork
      forever begin
        @(negedge clock);
        if (mon_en && !reset) begin
          if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
              chk("unexpected_result", result, -1);
            end else begin
              mon_e = sb.pop_front();
              chk("result", result, mon_e.res);
              chk("frame_done", frame_done, mon_e.fd);
              if (lat_arm) begin
                lat_arm = 0;
                chk("first_latency", cyc - acc12_cyc, 2);
              end
            end
          end
          if (!out_valid && frame_done) chk("frame_done_without_valid", frame_done, 0);
        end
      end
    join_none

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_result", result, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clock); #1;

    for (int t = 0; t < 4; t++) begin
      if (tbl[t].coef_all != 0) write_all(8'(tbl[t].coef_all));
      run_frame(tbl[t].ramp, tbl[t].toggle, tbl[t].seq, 1'b1, 25, t == 0);
      drain();
    end

    // Mid-frame reset: outputs of the partial frame are not scored.
    mon_en = 0;
    run_frame(1'b1, 1'b0, 0, 1'b0, 16, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_out_valid", out_valid, 0);
    chk("post_reset_in_ready", in_ready, 1);
    mon_en = 1;
    @(posedge clock); #1;
    run_frame(1'b1, 1'b0, 0, 1'b1, 25, 1'b0);
    drain();

    // Backpressure: hold the first result for three cycles.
    out_ready = 1'b0;
    fork
      run_frame(1'b1, 1'b0, 0, 1'b1, 25, 1'b0);
      begin
        for (int n = 0; n < 200 && !out_valid; n++) @(negedge clock);
        chk("bp_first_valid", out_valid, 1);
        for (int s = 0; s < 3; s++) begin
          if (s > 0) @(negedge clock);
          chk("bp_result_hold", result, 174);
          chk("bp_in_ready", in_ready, 0);
          @(posedge clock); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
